// File: rtl/fetch_ctrl.sv
`default_nettype none
//============================================================================
// Module   : fetch_ctrl
// Purpose  : Instruction-fetch sequencer. Turns soft-reset, redirect and
//            stall requests into a legal PC mux select and a fetch flush
//            every cycle, and owns the post-reset hold and flush windows.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active low
//            soft_rst     - synchronous restart at RESET_PC
//            redirect     - taken branch/JAL/JALR, target on ALU_result
//            stall_req    - hold current PC (level)
//            PC_sel       - 0=RESET_PC 1=hold 2=PC+4 3=ALU_result
//            should_br    - 1 = inject NOP into fetched instruction
//            fetch_valid  - instruction leaving IF is architecturally valid
//            state_dbg    - HOLD=0 RUN=1 STALL=2 FLUSH=3
//            redirect_cnt - accepted redirects (saturating)
//            stall_cnt    - cycles with PC_sel=1 (saturating)
// Options  : FETCH_CTRL_PERF_EN - when defined, builds the performance
//            counters; otherwise both counter ports are tied to 0.
// Revision : 1.0 - initial release
//============================================================================
module fetch_ctrl #(
    parameter int RESET_HOLD_CYCLES = 2,   // 1..255
    parameter int FLUSH_CYCLES      = 1,   // 1..15
    parameter int CNT_WIDTH         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 soft_rst,
    input  logic                 redirect,
    input  logic                 stall_req,
    output logic [1:0]           PC_sel,
    output logic                 should_br,
    output logic                 fetch_valid,
    output logic [1:0]           state_dbg,
    output logic [CNT_WIDTH-1:0] redirect_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [1:0] c_SEL_RESET = 2'd0;
    localparam logic [1:0] c_SEL_HOLD  = 2'd1;
    localparam logic [1:0] c_SEL_PC4   = 2'd2;
    localparam logic [1:0] c_SEL_ALU   = 2'd3;

    localparam logic [7:0] c_HOLD_RELOAD  = 8'(RESET_HOLD_CYCLES - 1);
    // The redirect cycle itself is the first flush cycle, so the FLUSH
    // state only has to cover the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [3:0] c_FLUSH_RELOAD = 4'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_cnt_nxt;
    logic [3:0] r_flush_cnt;
    logic [3:0] w_flush_cnt_nxt;
    logic [1:0] w_pc_sel;
    logic       w_should_br;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= c_HOLD_RELOAD;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        w_pc_sel        = c_SEL_PC4;
        w_should_br     = 1'b0;

        case (r_state)
            ST_HOLD: begin
                // Redirect and stall have no meaning before fetch starts.
                w_pc_sel    = c_SEL_RESET;
                w_should_br = 1'b1;
                if (soft_rst) begin
                    w_hold_cnt_nxt = c_HOLD_RELOAD;
                end else if (r_hold_cnt == 8'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - 8'd1;
                end
            end

            ST_RUN, ST_STALL: begin
                if (soft_rst) begin
                    w_pc_sel       = c_SEL_RESET;
                    w_should_br    = 1'b1;
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = c_HOLD_RELOAD;
                end else if (redirect) begin
                    w_pc_sel    = c_SEL_ALU;
                    w_should_br = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt     = ST_FLUSH;
                        w_flush_cnt_nxt = c_FLUSH_RELOAD;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (stall_req) begin
                    w_pc_sel    = c_SEL_HOLD;
                    w_state_nxt = ST_STALL;
                end else begin
                    w_pc_sel    = c_SEL_PC4;
                    w_state_nxt = ST_RUN;
                end
            end

            ST_FLUSH: begin
                w_should_br = 1'b1;
                if (soft_rst) begin
                    w_pc_sel       = c_SEL_RESET;
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = c_HOLD_RELOAD;
                end else if (redirect) begin
                    // A new target restarts the flush window.
                    w_pc_sel        = c_SEL_ALU;
                    w_flush_cnt_nxt = c_FLUSH_RELOAD;
                end else if (stall_req) begin
                    // Stalled cycles do not consume the flush window.
                    w_pc_sel = c_SEL_HOLD;
                end else begin
                    w_pc_sel = c_SEL_PC4;
                    if (r_flush_cnt == 4'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                    end
                end
            end

            default: begin
                w_pc_sel    = c_SEL_RESET;
                w_should_br = 1'b1;
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    assign PC_sel      = w_pc_sel;
    assign should_br   = w_should_br;
    assign state_dbg   = r_state;
    assign fetch_valid = ~w_should_br & (r_state != ST_HOLD) & (w_pc_sel != c_SEL_HOLD);

`ifdef FETCH_CTRL_PERF_EN
    logic                 w_redirect_acc;
    logic [CNT_WIDTH-1:0] r_redirect_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    assign w_redirect_acc = redirect & ~soft_rst & (r_state != ST_HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_redirect_acc && !(&r_redirect_cnt)) begin
                r_redirect_cnt <= r_redirect_cnt + 1'b1;
            end
            if ((w_pc_sel == c_SEL_HOLD) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign stall_cnt    = r_stall_cnt;
`else
    assign redirect_cnt = '0;
    assign stall_cnt    = '0;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage.
- Generates the 2-bit PC mux select and the fetch flush (should_br) from pipeline requests: soft reset, taken branch/jump redirect, and stall.
- Owns the post-reset hold window and multi-cycle flush windows, so the IF stage only ever sees a legal select every cycle.
- Sits beside the IF stage; inputs come from EX (redirect) and the hazard/memory logic (stall).

Parameters:
- RESET_HOLD_CYCLES, 2: cycles PC_sel is held at RESET after reset release or soft reset; legal range 1..255.
- FLUSH_CYCLES, 1: cycles should_br stays asserted per accepted redirect, counting the redirect cycle; legal range 1..15.
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- soft_rst  input  1  synchronous request to restart fetch at RESET_PC.
- redirect  input  1  taken branch/JAL/JALR resolved; the target is on ALU_result this cycle.
- stall_req  input  1  hold the current PC (level-sensitive).
- PC_sel  output  2  0=RESET_PC, 1=hold PC_reg_out, 2=PC+4, 3=ALU_result.
- should_br  output  1  1 = zero the fetched instruction (inject NOP).
- fetch_valid  output  1  1 = the instruction leaving IF this cycle is architecturally valid.
- state_dbg  output  2  encoded FSM state (HOLD=0, RUN=1, STALL=2, FLUSH=3).
- redirect_cnt  output  CNT_WIDTH  number of accepted redirects.
- stall_cnt  output  CNT_WIDTH  number of cycles spent with PC_sel=1 due to stall.

Behaviour:
- Async reset (rst=0):
  - state=HOLD, hold counter = RESET_HOLD_CYCLES-1, flush counter = 0, perf counters = 0.
  - Outputs while in reset: PC_sel=0, should_br=1, fetch_valid=0, state_dbg=0.
- Outputs are Mealy (combinational from state plus inputs); state and counters are registered.
- Per-cycle priority: soft_rst > redirect > stall_req > normal advance.
- HOLD:
  - PC_sel=0, should_br=1.
  - Counter decrements each cycle; at 0 the next state is RUN.
  - redirect and stall_req are ignored.
  - soft_rst reloads the counter.
- RUN:
  - soft_rst: PC_sel=0, should_br=1, next state HOLD with reloaded counter.
  - redirect: PC_sel=3, should_br=1. Next state is FLUSH with counter = FLUSH_CYCLES-2 if FLUSH_CYCLES>1, otherwise RUN.
  - stall_req: PC_sel=1, should_br=0, next state STALL.
  - Otherwise: PC_sel=2, should_br=0.
- STALL:
  - Same priority order as RUN.
  - stall_req=1 with no higher request: PC_sel=1, stay in STALL.
  - stall_req=0: PC_sel=2, next state RUN.
- FLUSH:
  - should_br=1 every cycle.
  - PC_sel=1 if stall_req, else 2. A stall does not decrement the flush counter.
  - Counter at 0 (with no stall): next state RUN.
  - A redirect in FLUSH gives PC_sel=3 and reloads the counter (the flush window restarts).
  - soft_rst moves to HOLD.
- fetch_valid = ~should_br and (state != HOLD) and (PC_sel != 1).
- Redirect latency: the target is selected in the same cycle redirect is seen (zero added latency).
- A redirect held high for N consecutive cycles is accepted every cycle. redirect_cnt counts each accepted cycle.
- rst asserted mid-FLUSH or mid-STALL: immediate return to the reset values; no partial state survives.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- When defined:
  - redirect_cnt increments on each accepted redirect (not in HOLD, not when pre-empted by soft_rst).
  - stall_cnt increments on each cycle with PC_sel=1.
  - Both saturate at all-ones and clear only on rst.
- When undefined:
  - Both ports are driven constant 0.
  - No counter flops are synthesized.

Test Plan:
- Release rst with RESET_HOLD_CYCLES=2 -> PC_sel=0 and should_br=1 for 2 cycles, then PC_sel=2, fetch_valid=1, state_dbg=1.
- In RUN, pulse redirect for 1 cycle with FLUSH_CYCLES=3 -> that cycle PC_sel=3 and should_br=1; next 2 cycles PC_sel=2 and should_br=1; then should_br=0.
- In RUN, hold stall_req for 4 cycles -> PC_sel=1 for 4 cycles with fetch_valid=0, then PC_sel=2; stall_cnt=4 (PERF_EN).
- Assert stall_req and redirect together -> PC_sel=3; then with stall_req still high, PC_sel=1; redirect_cnt=1.
- Assert soft_rst together with redirect in FLUSH -> PC_sel=0, state_dbg=0 next cycle, redirect_cnt unchanged.
- Drop rst low during STALL with stall_req=1 -> PC_sel=0, should_br=1 immediately (no clock edge); counters=0.
